// File: rtl/riscv_axi_rd_arb_pkg.sv
// Shared types for the 2:1 AXI4 read arbiter: requester ids, FSM states and
// the AR/R channel structs used on both the upstream and downstream ports.
package riscv_axi_rd_arb_pkg;

  localparam logic RD_REQ_EXU = 1'b0;
  localparam logic RD_REQ_IFU = 1'b1;

  typedef enum logic {RD_ARB_IDLE, RD_ARB_ISSUE} rd_arb_state_t;

  typedef struct packed {
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
  } ar_m_t;

  typedef struct packed {
    logic arready;
  } ar_s_t;

  typedef struct packed {
    logic rready;
  } r_m_t;

  typedef struct packed {
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } r_s_t;

endpackage

// File: rtl/riscv_order_fifo.sv
// 1-bit-wide FIFO recording which requester owns each outstanding burst,
// in the order the ARs were granted.
module riscv_order_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  // Extra MSB on each pointer distinguishes full from empty.
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Depth-1:0] mem_q, mem_d;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign head_o  = mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (push_i && !full_o) begin
      mem_d[wptr_q[AddrW-1:0]] = data_i;
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop_i && !empty_o) begin
      rptr_d = rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/riscv_axi_rd_arb.sv
// Round-robin 2:1 AXI4 read arbiter: EXU (0) and IFU (1) share one AR/R master
// port; R beats are steered back by the in-order grant-history FIFO.
module riscv_axi_rd_arb
  import riscv_axi_rd_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          RR_INIT         = 1'b0
) (
  input  logic  ACLK,
  input  logic  ARESETn,
  input  ar_m_t UP_AR_M [1:0],
  output ar_s_t UP_AR_S [1:0],
  input  r_m_t  UP_R_M  [1:0],
  output r_s_t  UP_R_S  [1:0],
  output ar_m_t DN_AR_M,
  input  ar_s_t DN_AR_S,
  input  r_s_t  DN_R_S,
  output r_m_t  DN_R_M,
  output logic  busy,
  output logic  err_unexp_r
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

  rd_arb_state_t   state_q, state_d;
  ar_m_t           ar_q, ar_d;
  logic [CntW-1:0] count_q, count_d;
  logic            rr_q, rr_d;
  logic            err_q, err_d;

  logic grant, winner, pop;
  logic fifo_head, fifo_full, fifo_empty;

  // Grant decision uses only registered state, so a same-cycle pop cannot open a slot.
  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    rr_d    = rr_q;
    winner  = RD_REQ_EXU;
    grant   = 1'b0;
    unique case (state_q)
      RD_ARB_IDLE: begin
        if (UP_AR_M[0].arvalid && UP_AR_M[1].arvalid) begin
          winner = rr_q;
        end else if (UP_AR_M[1].arvalid) begin
          winner = RD_REQ_IFU;
        end
        grant = ARESETn && (UP_AR_M[0].arvalid || UP_AR_M[1].arvalid) &&
                (count_q < MaxCnt) && !fifo_full;
        if (grant) begin
          ar_d    = UP_AR_M[winner];
          rr_d    = ~winner;
          state_d = RD_ARB_ISSUE;
        end
      end
      RD_ARB_ISSUE: begin
        if (DN_AR_S.arready) begin
          state_d = RD_ARB_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    DN_AR_M         = ar_q;
    DN_AR_M.arvalid = (state_q == RD_ARB_ISSUE);
    for (int i = 0; i < 2; i++) begin
      UP_AR_S[i].arready = grant && (int'(winner) == i);
      UP_R_S[i]          = '0;
      if (!fifo_empty && (int'(fifo_head) == i)) begin
        UP_R_S[i] = DN_R_S;
      end
    end
    DN_R_M.rready = !fifo_empty && UP_R_M[fifo_head].rready;
  end

  assign pop     = !fifo_empty && DN_R_S.rvalid && DN_R_M.rready && DN_R_S.rlast;
  assign count_d = count_q + CntW'(grant) - CntW'(pop);
  assign err_d   = err_q | (DN_R_S.rvalid && fifo_empty);

  assign busy        = (state_q == RD_ARB_ISSUE) || (count_q != '0);
  assign err_unexp_r = err_q;

  riscv_order_fifo #(
    .Depth (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk_i   (ACLK),
    .rst_ni  (ARESETn),
    .push_i  (grant),
    .data_i  (winner),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= RD_ARB_IDLE;
      ar_q    <= '0;
      count_q <= '0;
      rr_q    <= RR_INIT;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_riscv_axi_rd_arb.sv
// Randomized bench for riscv_axi_rd_arb against a queue-based model of the
// arbiter plus a simple in-order memory responder.
module tb_riscv_axi_rd_arb;
  import riscv_axi_rd_arb_pkg::*;

  localparam int unsigned MaxOut = 4;
  localparam bit          RrInit = 1'b0;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  ar_m_t up_ar_m [1:0];
  ar_s_t up_ar_s [1:0];
  r_m_t  up_r_m  [1:0];
  r_s_t  up_r_s  [1:0];
  ar_m_t dn_ar_m;
  ar_s_t dn_ar_s;
  r_s_t  dn_r_s;
  r_m_t  dn_r_m;
  logic  busy, err;

  always #5 clk = ~clk;

  riscv_axi_rd_arb #(
    .MAX_OUTSTANDING (MaxOut),
    .RR_INIT         (RrInit)
  ) dut (
    .ACLK        (clk),
    .ARESETn     (rst_n),
    .UP_AR_M     (up_ar_m),
    .UP_AR_S     (up_ar_s),
    .UP_R_M      (up_r_m),
    .UP_R_S      (up_r_s),
    .DN_AR_M     (dn_ar_m),
    .DN_AR_S     (dn_ar_s),
    .DN_R_S      (dn_r_s),
    .DN_R_M      (dn_r_m),
    .busy        (busy),
    .err_unexp_r (err)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Model: owner of every accepted-but-unfinished burst, oldest first.
  int    owner_q[$];
  bit    m_issue;
  ar_m_t m_ar;
  bit    m_rr;
  bit    m_err;
  // Memory: lengths of downstream-accepted bursts not yet fully returned.
  int    mem_len_q[$];
  int    mem_beat;
  bit    clr_up [2];
  bit    clr_r;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_quiet(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq({tag, "_arready"}, up_ar_s[i].arready, 1'b0);
      check_eq({tag, "_up_rvalid"}, up_r_s[i].rvalid, 1'b0);
    end
    check_eq({tag, "_dn_arvalid"}, dn_ar_m.arvalid, 1'b0);
    check_eq({tag, "_dn_rready"}, dn_r_m.rready, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic clear_all();
    for (int i = 0; i < 2; i++) begin
      up_ar_m[i] = '0;
      up_r_m[i]  = '0;
      clr_up[i]  = 1'b0;
    end
    dn_ar_s = '0;
    dn_r_s  = '0;
    clr_r   = 1'b0;
    owner_q.delete();
    mem_len_q.delete();
    mem_beat = 0;
    m_issue  = 1'b0;
    m_ar     = '0;
    m_rr     = RrInit;
    m_err    = 1'b0;
  endtask

  // Asserts reset between clock edges and checks outputs drop with no clock.
  task automatic reset_now(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_quiet(tag);
    check_eq({tag, "_err"}, err, 1'b0);
    clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int p_req, input int p_dnrdy, input int p_rv, input int p_rr);
    bit exp_grant, w, has, pop, dn_hs, r_hs;
    int h;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (clr_up[i]) begin
        up_ar_m[i].arvalid = 1'b0;
        clr_up[i] = 1'b0;
      end
    end
    if (clr_r) begin
      dn_r_s.rvalid = 1'b0;
      clr_r = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (!up_ar_m[i].arvalid && $urandom_range(99) < p_req) begin
        up_ar_m[i].arid    = 4'(i);
        up_ar_m[i].araddr  = $urandom;
        up_ar_m[i].arlen   = 8'($urandom_range(3));
        up_ar_m[i].arsize  = 3'd2;
        up_ar_m[i].arburst = 2'b01;
        up_ar_m[i].arvalid = 1'b1;
      end
      up_r_m[i].rready = ($urandom_range(99) < p_rr);
    end
    dn_ar_s.arready = ($urandom_range(99) < p_dnrdy);
    if (!dn_r_s.rvalid && mem_len_q.size() > 0 && $urandom_range(99) < p_rv) begin
      dn_r_s.rid    = 4'd0;
      dn_r_s.rdata  = $urandom;
      dn_r_s.rresp  = 2'b00;
      dn_r_s.rlast  = (mem_beat == mem_len_q[0]);
      dn_r_s.rvalid = 1'b1;
    end
    #1;
    // Expected outputs from the model's current state.
    exp_grant = !m_issue && owner_q.size() < MaxOut &&
                (up_ar_m[0].arvalid || up_ar_m[1].arvalid);
    w = (up_ar_m[0].arvalid && up_ar_m[1].arvalid) ? m_rr : up_ar_m[1].arvalid;
    for (int i = 0; i < 2; i++) begin
      check_eq("up_arready", up_ar_s[i].arready, exp_grant && (int'(w) == i));
    end
    check_eq("dn_arvalid", dn_ar_m.arvalid, m_issue);
    if (m_issue) begin
      check_eq("dn_araddr", dn_ar_m.araddr, m_ar.araddr);
      check_eq("dn_arlen", dn_ar_m.arlen, m_ar.arlen);
      check_eq("dn_arid", dn_ar_m.arid, m_ar.arid);
    end
    has = owner_q.size() > 0;
    h = has ? owner_q[0] : 0;
    for (int i = 0; i < 2; i++) begin
      check_eq("up_rvalid", up_r_s[i].rvalid, (has && h == i) ? dn_r_s.rvalid : 1'b0);
    end
    if (has && dn_r_s.rvalid) begin
      check_eq("up_rdata", up_r_s[h].rdata, dn_r_s.rdata);
      check_eq("up_rlast", up_r_s[h].rlast, dn_r_s.rlast);
    end
    check_eq("dn_rready", dn_r_m.rready, has ? up_r_m[h].rready : 1'b0);
    check_eq("busy", busy, m_issue || has);
    check_eq("err", err, m_err);

    // Advance model, memory and requester bookkeeping across the next edge.
    pop   = has && dn_r_s.rvalid && up_r_m[h].rready && dn_r_s.rlast;
    dn_hs = dn_ar_m.arvalid && dn_ar_s.arready;
    r_hs  = dn_r_s.rvalid && dn_r_m.rready;
    if (dn_r_s.rvalid && !has) m_err = 1'b1;
    if (exp_grant) begin
      owner_q.push_back(int'(w));
      m_ar      = up_ar_m[w];
      m_issue   = 1'b1;
      m_rr      = ~w;
      clr_up[w] = 1'b1;
    end else if (m_issue && dn_ar_s.arready) begin
      m_issue = 1'b0;
    end
    if (pop) void'(owner_q.pop_front());
    if (dn_hs) mem_len_q.push_back(int'(dn_ar_m.arlen));
    if (r_hs && mem_len_q.size() > 0) begin
      clr_r = 1'b1;
      if (dn_r_s.rlast) begin
        void'(mem_len_q.pop_front());
        mem_beat = 0;
      end else begin
        mem_beat++;
      end
    end
  endtask

  typedef struct {
    int p_req;
    int p_dnrdy;
    int p_rv;
    int p_rr;
    int cycles;
  } phase_t;

  phase_t phases[$] = '{
    '{100, 100, 60, 100, 200},
    '{80, 50, 40, 70, 800},
    '{100, 100, 0, 100, 40},
    '{60, 70, 70, 50, 800},
    '{100, 30, 50, 20, 600},
    '{30, 90, 90, 90, 400}
  };

  initial begin
    bit reached;
    clear_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    check_eq("reset_err", err, 1'b0);
    rst_n = 1'b1;

    // Spurious R beat with nothing outstanding sets the sticky error.
    @(negedge clk);
    dn_r_s.rvalid = 1'b1;
    dn_r_s.rlast  = 1'b1;
    #1;
    check_quiet("unexp");
    check_eq("unexp_err_before", err, 1'b0);
    @(negedge clk);
    dn_r_s = '0;
    #1;
    check_eq("unexp_err_set", err, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check_eq("unexp_err_sticky", err, 1'b1);
    reset_now("rst_err");

    foreach (phases[p]) begin
      for (int c = 0; c < phases[p].cycles; c++) begin
        step(phases[p].p_req, phases[p].p_dnrdy, phases[p].p_rv, phases[p].p_rr);
      end
    end

    // Build ISSUE with two bursts outstanding, then reset mid-flight.
    reached = 1'b0;
    for (int c = 0; c < 500 && !reached; c++) begin
      step(100, 20, 0, 100);
      reached = m_issue && owner_q.size() >= 2;
    end
    check_eq("reach_issue2", reached, 1'b1);
    reset_now("rst_mid");

    // Both requesters contend straight after reset: RR_INIT must win.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      up_ar_m[i].arid    = 4'(i);
      up_ar_m[i].araddr  = 32'h100 + 32'(i);
      up_ar_m[i].arvalid = 1'b1;
    end
    #1;
    check_eq("rr_init_win", up_ar_s[RrInit].arready, 1'b1);
    check_eq("rr_init_lose", up_ar_s[~RrInit].arready, 1'b0);
    rst_n = 1'b0;
    #1;
    clear_all();
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 400; c++) step(70, 60, 60, 70);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
